// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: read-return owner encoding, default widths and counter limits for the data-RAM arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones, cleared asynchronously by rstn
module sat_counter
  import dmem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLOCK_50,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge CLOCK_50 or negedge rstn)
    if (!rstn) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage (priority) and a host port with bounded wait
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  rstn,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_index,
  output logic [DATA_WIDTH-1:0] mem_entry,
  input  logic [DATA_WIDTH-1:0] mem_entry_out,
  output logic [CNT_W-1:0]      host_grants,
  output logic [CNT_W-1:0]      cpu_stall_cycles
);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
  logic [7:0] wait_cnt, wait_nx;
  logic       force_h, grant_host, grant_cpu;
  owner_t     owner, owner_nx;
  // grants are qualified by rstn so every output is quiet while reset is held
  always_comb begin
    force_h     = host_valid && (wait_cnt == WAIT_LIM);
    grant_host  = rstn && host_valid && (!cpu_req || force_h);
    grant_cpu   = rstn && cpu_req && !grant_host;
    host_ready  = grant_host;
    cpu_stall   = cpu_req && grant_host;
    mem_wr_en   = grant_host ? host_we : (grant_cpu && cpu_we);
    mem_index   = grant_host ? host_addr : grant_cpu ? cpu_addr : '0;
    mem_entry   = grant_host ? host_wdata : grant_cpu ? cpu_wdata : '0;
    wait_nx     = (grant_host || !host_valid) ? '0 : (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 8'd1;
    owner_nx    = (grant_cpu && !cpu_we) ? OWN_CPU : (grant_host && !host_we) ? OWN_HOST : OWN_NONE;
    cpu_rvalid  = (owner == OWN_CPU);
    host_rvalid = (owner == OWN_HOST);
    cpu_rdata   = cpu_rvalid ? mem_entry_out : '0;
    host_rdata  = host_rvalid ? mem_entry_out : '0;
  end
  always_ff @(posedge CLOCK_50 or negedge rstn)
    if (!rstn) begin
      owner    <= OWN_NONE;
      wait_cnt <= '0;
    end else begin
      owner    <= owner_nx;
      wait_cnt <= wait_nx;
    end
  sat_counter #(.W(CNT_W)) u_host_grants (
    .CLOCK_50(CLOCK_50),
    .rstn    (rstn),
    .inc     (grant_host),
    .count   (host_grants)
  );
  sat_counter #(.W(CNT_W)) u_stall_cycles (
    .CLOCK_50(CLOCK_50),
    .rstn    (rstn),
    .inc     (cpu_stall),
    .count   (cpu_stall_cycles)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a cycle-level behavioural model
module tb_dmem_arbiter;
  localparam int MW = 8;
  logic        CLOCK_50 = 0;
  logic        rstn;
  logic        cpu_req, cpu_we, host_valid, host_we;
  logic [9:0]  cpu_addr, host_addr;
  logic [31:0] cpu_wdata, host_wdata;
  logic        cpu_stall, cpu_rvalid, host_ready, host_rvalid, mem_wr_en;
  logic [31:0] cpu_rdata, host_rdata, mem_entry, mem_entry_out;
  logic [9:0]  mem_index;
  logic [15:0] host_grants, cpu_stall_cycles;
  logic        z_cpu_req, z_host_valid, z_cpu_stall, z_cpu_rvalid, z_host_ready, z_host_rvalid, z_mem_wr_en;
  logic [31:0] z_cpu_rdata, z_host_rdata, z_mem_entry;
  logic [9:0]  z_mem_index;
  logic [15:0] z_host_grants, z_cpu_stall_cycles;
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  int          tests = 0, fails = 0;
  int          refused, hg, cs, n;
  logic        exp_cv, exp_hv, rdy, o_hrv, o_crv;
  logic [31:0] exp_rd, o_hrd, o_crd;
  logic [15:0] o_csc;

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (mem_wr_en) ram[mem_index] <= mem_entry;
    mem_entry_out <= ram[mem_index];
  end

  dmem_arbiter #(.MAX_WAIT(MW)) u_dut (
    .CLOCK_50(CLOCK_50), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_wr_en(mem_wr_en), .mem_index(mem_index), .mem_entry(mem_entry), .mem_entry_out(mem_entry_out),
    .host_grants(host_grants), .cpu_stall_cycles(cpu_stall_cycles)
  );

  dmem_arbiter #(.MAX_WAIT(0)) u_dut0 (
    .CLOCK_50(CLOCK_50), .rstn(rstn),
    .cpu_req(z_cpu_req), .cpu_we(1'b1), .cpu_addr(10'd1), .cpu_wdata(32'h1),
    .cpu_stall(z_cpu_stall), .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
    .host_valid(z_host_valid), .host_ready(z_host_ready), .host_we(1'b1), .host_addr(10'd2),
    .host_wdata(32'h2), .host_rvalid(z_host_rvalid), .host_rdata(z_host_rdata),
    .mem_wr_en(z_mem_wr_en), .mem_index(z_mem_index), .mem_entry(z_mem_entry), .mem_entry_out(32'h0),
    .host_grants(z_host_grants), .cpu_stall_cycles(z_cpu_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    refused = 0;
    hg = 0;
    cs = 0;
    exp_cv = 0;
    exp_hv = 0;
    exp_rd = 0;
  endtask

  // one clock: compare every output with the model at the negedge, then advance the model
  task automatic cycle();
    logic hw, cw, we;
    logic [9:0] a;
    logic [31:0] d;
    @(negedge CLOCK_50);
    hw = host_valid && (!cpu_req || refused >= MW);
    cw = cpu_req && !hw;
    we = hw ? host_we : (cw && cpu_we);
    a  = hw ? host_addr : cw ? cpu_addr : 10'd0;
    d  = hw ? host_wdata : cw ? cpu_wdata : 32'd0;
    check("host_ready", {31'd0, host_ready}, {31'd0, hw});
    check("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && hw});
    check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, we});
    check("mem_index", {22'd0, mem_index}, {22'd0, a});
    check("mem_entry", mem_entry, d);
    check("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_cv});
    check("cpu_rdata", cpu_rdata, exp_cv ? exp_rd : 32'd0);
    check("host_rvalid", {31'd0, host_rvalid}, {31'd0, exp_hv});
    check("host_rdata", host_rdata, exp_hv ? exp_rd : 32'd0);
    check("host_grants", {16'd0, host_grants}, hg);
    check("cpu_stall_cycles", {16'd0, cpu_stall_cycles}, cs);
    rdy = host_ready;
    o_hrv = host_rvalid;
    o_hrd = host_rdata;
    o_crv = cpu_rvalid;
    o_crd = cpu_rdata;
    o_csc = cpu_stall_cycles;
    exp_cv = cw && !cpu_we;
    exp_hv = hw && !host_we;
    exp_rd = ref_mem[a];
    if (we) ref_mem[a] = d;
    refused = (host_valid && !hw) ? refused + 1 : 0;
    if (hw && hg < 65535) hg++;
    if (cpu_req && hw && cs < 65535) cs++;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0;
    cpu_we = 0;
    cpu_addr = 0;
    cpu_wdata = 0;
    host_valid = 0;
    host_we = 0;
    host_addr = 0;
    host_wdata = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {31'd0, host_ready}, 0);
    check({tag, "_stall"}, {31'd0, cpu_stall}, 0);
    check({tag, "_wr_en"}, {31'd0, mem_wr_en}, 0);
    check({tag, "_index"}, {22'd0, mem_index}, 0);
    check({tag, "_entry"}, mem_entry, 0);
    check({tag, "_rvalid"}, {30'd0, cpu_rvalid, host_rvalid}, 0);
    check({tag, "_rdata"}, cpu_rdata | host_rdata, 0);
    check({tag, "_counts"}, {host_grants, cpu_stall_cycles}, 0);
  endtask

  task automatic do_reset();
    rstn = 0;
    cpu_req = 1;
    host_valid = 1;
    host_we = 1;
    cpu_we = 1;
    #2;
    check_quiet("rst");
    repeat (2) @(posedge CLOCK_50);
    #1;
    rstn = 1;
    idle();
    model_reset();
  endtask

  initial begin
    idle();
    z_cpu_req = 0;
    z_host_valid = 0;
    rstn = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    model_reset();
    #3;
    check_quiet("por");
    do_reset();
    host_valid = 1; host_we = 1; host_addr = 5; host_wdata = 32'hA5A5;
    cycle();
    check("ho_wr_ready", {31'd0, rdy}, 1);
    host_we = 0;
    cycle();
    idle();
    cycle();
    check("ho_rvalid", {31'd0, o_hrv}, 1);
    check("ho_rdata", o_hrd, 32'hA5A5);
    cpu_req = 1; cpu_we = 1; cpu_addr = 3; cpu_wdata = 32'h3333_0003;
    cycle();
    cpu_addr = 4; cpu_wdata = 32'h4444_0004;
    cycle();
    cpu_we = 0; cpu_addr = 3;
    cycle();
    cpu_addr = 4;
    cycle();
    check("b2b_rv0", {30'd0, o_crv, o_hrv}, 2);
    check("b2b_rd0", o_crd, 32'h3333_0003);
    idle();
    cycle();
    check("b2b_rv1", {30'd0, o_crv, o_hrv}, 2);
    check("b2b_rd1", o_crd, 32'h4444_0004);
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7;
    host_valid = 1; host_we = 1; host_addr = 9; host_wdata = 32'hBEEF;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      cycle();
      if (rdy) n = i;
    end
    check("starve_lat", n, MW + 1);
    host_valid = 0;
    cycle();
    check("starve_stalls", {16'd0, o_csc}, 1);
    host_valid = 1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      cycle();
      if (rdy) n = i;
    end
    check("starve_again", n, MW + 1);
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 11; cpu_wdata = 32'h11;
    host_valid = 1; host_we = 0; host_addr = 12;
    repeat (5) cycle();
    host_valid = 0;
    cycle();
    host_valid = 1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      cycle();
      if (rdy) n = i;
    end
    check("drop_lat", n, MW + 1);
    idle();
    cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 3;
    @(negedge CLOCK_50);
    check("midrd_grant", {22'd0, mem_index}, 3);
    rstn = 0;
    #1;
    check_quiet("midrd");
    repeat (2) @(posedge CLOCK_50);
    #1;
    rstn = 1;
    idle();
    model_reset();
    cycle();
    check("midrd_norv", {31'd0, o_crv}, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!host_valid || rdy) begin
        host_valid = ($urandom_range(0, 99) < 50);
        host_we = $urandom_range(0, 1);
        host_addr = 10'($urandom_range(0, 15));
        host_wdata = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        host_valid = 0;
      end
      cpu_req = ($urandom_range(0, 99) < 75);
      cpu_we = $urandom_range(0, 1);
      cpu_addr = 10'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      cycle();
    end
    idle();
    cycle();
    z_cpu_req = 1;
    z_host_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      check("mw0_ready", {31'd0, z_host_ready}, 1);
      check("mw0_stall", {31'd0, z_cpu_stall}, 1);
      check("mw0_index", {22'd0, z_mem_index}, 2);
    end
    repeat (70000) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("mw0_grants_sat", {16'd0, z_host_grants}, 32'hFFFF);
    check("mw0_stall_sat", {16'd0, z_cpu_stall_cycles}, 32'hFFFF);
    check("mw0_stall_hold", {31'd0, z_cpu_stall}, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
